exp_stream_unit: RTL

Streaming exponential stage for the softmax datapath. It accepts one IEEE-754 single per cycle holding a max-subtracted score x ≤ 0. It returns exp(x) as unsigned fixed point and tags frame boundaries every NUM_DATA elements. Compared with the fixed 10-element exp stage it is fully pipelined at one element per cycle, has valid/ready backpressure, and exposes width and depth parameters. It sits between the max-subtract stage and the divider.

---
 rtl/exp_stream_unit.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/exp_stream_unit.sv
// -----------------------------------------------------------------------------
// exp_stream_unit
//
// Streaming exponential stage of the softmax datapath. Each cycle it can take
// one FP32 max-subtracted score x <= 0 and produce exp(x) as unsigned fixed
// point Q1.(OUT_W-1). It tags every NUM_DATA-th output as the frame's last
// element.
//
// Pipeline (one global advance enable, valid/ready backpressure):
//   S1  FP32 -> |x| fixed point, split into integer index k and fraction index
//   S2  integer LUT and fraction LUT reads
//   S3  ILUT x FLUT full-width product
//   OUT round half-up to OUT_W bits -> exp_o
//
// Optional feature macro: EXP_SUM_EN
//   defined   : per-frame sum of exp_o on sum_o / sum_valid_o
//   undefined : sum_o and sum_valid_o are tied to 0
//
// Ports
//   clock_i       in   clock, rising edge
//   reset_n_i     in   asynchronous active-low reset
//   data_i        in   FP32 input score
//   data_valid_i  in   input valid
//   data_ready_o  out  input ready (combinational from exp_ready_i)
//   exp_o         out  exp(x), Q1.(OUT_W-1)
//   exp_valid_o   out  output valid
//   exp_ready_i   in   downstream ready
//   exp_last_o    out  marks the NUM_DATA-th output of a frame
//   frame_done_o  out  one-cycle pulse after the last output of a frame is taken
//   sum_o         out  frame sum of exp_o (EXP_SUM_EN only)
//   sum_valid_o   out  sum_o valid (EXP_SUM_EN only)
// -----------------------------------------------------------------------------
module exp_stream_unit #(
    parameter int NUM_DATA  = 10,
    parameter int INT_BITS  = 4,
    parameter int FRAC_BITS = 16,
    parameter int LUT_IDX   = 6,
    parameter int OUT_W     = 32,
    parameter int CNT_W     = $clog2(NUM_DATA + 1)
) (
    input  logic                   clock_i,
    input  logic                   reset_n_i,
    input  logic [31:0]            data_i,
    input  logic                   data_valid_i,
    output logic                   data_ready_o,
    output logic [OUT_W-1:0]       exp_o,
    output logic                   exp_valid_o,
    input  logic                   exp_ready_i,
    output logic                   exp_last_o,
    output logic                   frame_done_o,
    output logic [OUT_W+CNT_W-1:0] sum_o,
    output logic                   sum_valid_o
);

    localparam int IDX_W = INT_BITS + LUT_IDX;        // {k, f_top}
    localparam int EXT_W = 24 + INT_BITS + FRAC_BITS; // significand plus headroom
    localparam int PRD_W = 2 * OUT_W;
    localparam int LP_Q  = 60;                        // LUT builder precision

    localparam logic [PRD_W-1:0] P_RND = PRD_W'(1) << (OUT_W - 2);

    // -------------------------------------------------------------------------
    // Elaboration-time LUT builder: round(e^-(num / 2^shift) * 2^(OUT_W-1)).
    // e^-(1/2^shift) is summed as a Taylor series in Q60 integer arithmetic,
    // then raised to the num-th power by repeated multiplication. The error
    // stays many orders of magnitude below one output LSB.
    // -------------------------------------------------------------------------
    function automatic logic [OUT_W-1:0] exp_neg_entry(input int num, input int shift);
        logic [127:0] term;
        logic [127:0] base;
        logic [127:0] acc;
        term = 128'(1) << LP_Q;
        base = term;
        for (int n = 1; n < 28; n++) begin
            term = term / (128'(n) << shift);
            if (n % 2 == 1) base = base - term;
            else            base = base + term;
        end
        acc = 128'(1) << LP_Q;
        for (int i = 0; i < num; i++) begin
            acc = (acc * base) >> LP_Q;
        end
        acc = (acc + (128'(1) << (LP_Q - OUT_W))) >> (LP_Q + 1 - OUT_W);
        return OUT_W'(acc);
    endfunction

    logic [OUT_W-1:0] w_ilut [2**INT_BITS];
    logic [OUT_W-1:0] w_flut [2**LUT_IDX];

    for (genvar g = 0; g < 2**INT_BITS; g++) begin : g_ilut
        localparam logic [OUT_W-1:0] LP_VAL = exp_neg_entry(g, 0);
        assign w_ilut[g] = LP_VAL;
    end

    for (genvar g = 0; g < 2**LUT_IDX; g++) begin : g_flut
        localparam logic [OUT_W-1:0] LP_VAL = exp_neg_entry(g, LUT_IDX);
        assign w_flut[g] = LP_VAL;
    end

    // -------------------------------------------------------------------------
    // Handshake / advance
    // -------------------------------------------------------------------------
    logic             r_out_valid;
    logic [OUT_W-1:0] r_out;
    logic [CNT_W-1:0] r_cnt;
    logic             r_frame_done;
    logic             w_adv;
    logic             w_out_hs;
    logic             w_last;

    // The whole pipe freezes only when the output register is full and not
    // being drained; bubbles inside the pipe are not squeezed out.
    assign w_adv        = !(r_out_valid && !exp_ready_i);
    assign data_ready_o = w_adv;
    assign w_out_hs     = r_out_valid && exp_ready_i;
    assign w_last       = (r_cnt == CNT_W'(NUM_DATA - 1));

    assign exp_o        = r_out;
    assign exp_valid_o  = r_out_valid;
    assign exp_last_o   = w_last && r_out_valid;
    assign frame_done_o = r_frame_done;

    // -------------------------------------------------------------------------
    // S1 decode: FP32 -> {k, f_top}
    // The significand is placed at the top of a wide vector and shifted right
    // so that the result is floor(|x| * 2^LUT_IDX); low fraction bits drop out.
    // -------------------------------------------------------------------------
    logic             w_zero;
    logic             w_uf;
    logic [EXT_W-1:0] w_ext;
    logic [9:0]       w_shamt;
    logic [IDX_W-1:0] w_idx;

    // NOTE: every output of a combinational block gets a default first so no
    // path through it can leave a value held, which would infer a latch.
    always_comb begin
        w_zero  = 1'b0;
        w_uf    = 1'b0;
        w_idx   = '0;
        w_ext   = {1'b1, data_i[22:0], (INT_BITS + FRAC_BITS)'(0)};
        w_shamt = 10'(INT_BITS + 150 + FRAC_BITS - LUT_IDX) - {2'b00, data_i[30:23]};
        // Positive values and zero/denormal exponents both mean |x| = 0.
        w_zero  = !data_i[31] || (data_i[30:23] == 8'd0);
        // Exponent 255 (NaN/Inf) lands here as well and reads as underflow.
        w_uf    = !w_zero && ({1'b0, data_i[30:23]} >= 9'(127 + INT_BITS));
        if (!w_zero && !w_uf) begin
            w_idx = IDX_W'(w_ext >> w_shamt);
        end
    end

    // -------------------------------------------------------------------------
    // Pipeline registers
    // -------------------------------------------------------------------------
    logic             r_s1_valid;
    logic [IDX_W-1:0] r_s1_idx;
    logic             r_s1_uf;
    logic             r_s2_valid;
    logic [OUT_W-1:0] r_s2_ilut;
    logic [OUT_W-1:0] r_s2_flut;
    logic             r_s2_uf;
    logic             r_s3_valid;
    logic [PRD_W-1:0] r_s3_prod;
    logic [OUT_W-1:0] w_round;

    // Product never exceeds 2^(2*OUT_W-2), so the rounded value fits OUT_W.
    assign w_round = OUT_W'((r_s3_prod + P_RND) >> (OUT_W - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its source, independent of block order.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            // NOTE: data registers are reset too, not just the valids, because
            // exp_o must read 0 during reset; the LUTs are constants and need none.
            r_s1_valid  <= 1'b0;
            r_s1_idx    <= '0;
            r_s1_uf     <= 1'b0;
            r_s2_valid  <= 1'b0;
            r_s2_ilut   <= '0;
            r_s2_flut   <= '0;
            r_s2_uf     <= 1'b0;
            r_s3_valid  <= 1'b0;
            r_s3_prod   <= '0;
            r_out_valid <= 1'b0;
            r_out       <= '0;
        end else if (w_adv) begin
            r_s1_valid  <= data_valid_i;
            r_s1_idx    <= w_idx;
            r_s1_uf     <= w_uf;

            r_s2_valid  <= r_s1_valid;
            r_s2_ilut   <= w_ilut[r_s1_idx[IDX_W-1 -: INT_BITS]];
            r_s2_flut   <= w_flut[r_s1_idx[LUT_IDX-1:0]];
            r_s2_uf     <= r_s1_uf;

            r_s3_valid  <= r_s2_valid;
            r_s3_prod   <= r_s2_uf ? '0 : PRD_W'(r_s2_ilut) * PRD_W'(r_s2_flut);

            r_out_valid <= r_s3_valid;
            r_out       <= w_round;
        end
    end

    // -------------------------------------------------------------------------
    // Frame counter and frame_done pulse
    // -------------------------------------------------------------------------
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_cnt        <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_out_hs && w_last;
            if (w_out_hs) begin
                r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Optional frame sum
    // -------------------------------------------------------------------------
`ifdef EXP_SUM_EN
    logic [OUT_W+CNT_W-1:0] r_acc;
    logic [OUT_W+CNT_W-1:0] r_sum;
    logic                   r_sum_valid;
    logic [OUT_W+CNT_W-1:0] w_acc_next;

    assign w_acc_next  = r_acc + (OUT_W + CNT_W)'(r_out);
    assign sum_o       = r_sum;
    assign sum_valid_o = r_sum_valid;

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_acc       <= '0;
            r_sum       <= '0;
            r_sum_valid <= 1'b0;
        end else if (w_out_hs) begin
            // sum_valid_o is set by the last element and cleared by the next
            // taken output, so it stays up across stalls between frames.
            r_sum_valid <= w_last;
            if (w_last) begin
                r_sum <= w_acc_next;
                r_acc <= '0;
            end else begin
                r_acc <= w_acc_next;
            end
        end
    end
`else
    assign sum_o       = '0;
    assign sum_valid_o = 1'b0;
`endif

endmodule
